dpll_phase_track: RTL and testbench
===================================

# dpll_phase_track

Digital phase-tracking loop that consumes the one-cycle rising-edge pulses from the edge oversampler. It compares each edge against a local divide-by-DIV counter and filters lead/lag votes through a random-walk (K) counter. It then adds or deletes one count in the divider to pull the recovered clock into phase with the input. Its outputs are the recovered clock, a symbol tick, and lock status for downstream bit-sampling logic.

## Interface
- DIV, 50: nominal divide ratio; the recovered clock period is DIV cycles of clk_50K; DIV ≥ 8, even.
- K, 4: random-walk threshold, i.e. the number of net votes needed for one correction; 1 ≤ K ≤ 15.
- LOCK_N, 8: consecutive in-phase edges required to assert locked.
- clk_50K  in  1  system sample clock; all logic uses its rising edge.
- rst_n  in  1  synchronous active-low reset.
- pulse  in  1  one-cycle input-edge strobe from the oversampler.
- rclk  out  1  recovered clock: 0 while cnt < DIV/2, 1 otherwise.
- sync_tick  out  1  one-cycle strobe on the cycle cnt wraps to 0.
- lead  out  1  one-cycle strobe: the last edge was a lead vote.
- lag  out  1  one-cycle strobe: the last edge was a lag vote.
- locked  out  1  loop-in-phase status.

## Operation
- **Divider.** cnt counts 0 up to its terminal value, then wraps to 0.
  - Terminal value is DIV-1 normally, DIV-2 when a shorten correction is pending, and DIV when a lengthen correction is pending.
  - At most one correction per period. The pending flag clears on the wrap that applies it.
- **Phase detector.** Evaluated on cycles where pulse=1, using the current registered cnt.
  - cnt == 0, or cnt == DIV: in-phase. No vote, err = 0.
  - 1 ≤ cnt ≤ DIV/2: lead vote, err = cnt. The local clock is early; the loop lengthens.
  - DIV/2 < cnt ≤ DIV-1: lag vote, err = DIV - cnt. The local clock is late; the loop shortens.
- **Random-walk filter.** acc is a signed counter in [-K, +K].
  - A lag vote does acc+1; a lead vote does acc-1.
  - When an update reaches +K: acc goes to 0 and pend_short is set.
  - When an update reaches -K: acc goes to 0 and pend_long is set.
  - A request arriving while the same-direction flag is already pending: flag stays set (no stacking), acc goes to 0.
  - A request arriving while the opposite flag is pending: both flags clear, acc goes to 0 (the requests cancel).
- **Lock detector.** Uses a run counter and a silence counter.
  - Edge with err ≤ 1: run increments, saturating at LOCK_N. locked=1 once run reaches LOCK_N.
  - Edge with err > 1: run goes to 0, locked goes to 0.
  - Silence counter resets on every pulse. If it reaches 4·DIV cycles: locked=0, run=0.
- **Reset.** rst_n=0 forces cnt=0, acc=0, pend_short=pend_long=0, run=0, silence=0.
  - All outputs read 0 on the cycle after reset: rclk, sync_tick, lead, lag, locked.
  - Reset wins over a simultaneous pulse. Asserting it mid-correction discards the pending correction.

## Timing
- **Pulse response.** For a pulse sampled at edge t:
  - lead/lag are high for exactly cycle t+1.
  - acc and the pending flags hold their new values from t+1.
  - locked updates at t+1.
- **Correction latency.** A pending flag set at t+1 affects the first wrap at or after t+1.
  - If cnt is already past the shortened terminal (DIV-2) when pend_short sets, the correction applies at the next period's wrap instead.
- **Tick and rclk.**
  - sync_tick is high in the cycle where cnt==0 after a wrap. It is not asserted in the first cycle out of reset.
  - rclk is registered from cnt, so it lags cnt by one cycle.
- **Pulse on a wrap cycle.** Phase is judged on the pre-wrap cnt value.
- **Pulse spacing.** Back-to-back pulses in consecutive cycles are each evaluated independently.
- **Widths.** cnt is clog2(DIV+1) bits; acc is 5-bit signed; silence is clog2(4·DIV+1) bits. None of them may wrap silently.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles while driving pulse=1 -> all outputs 0. After release, the first sync_tick comes 50 cycles later, then every 50 cycles; rclk runs 25 low / 25 high.
- **Lead pull-in:** pulses every 50 cycles arriving at cnt=10 -> lead strobes. After the 4th pulse pend_long is set and the next period is 51 cycles; repeating, the edge converges toward cnt=0 and lead stops.
- **Lag pull-in:** pulses arriving at cnt=40 -> lag strobes, a 49-cycle period after every 4 votes, until arrival is at cnt=0.
- **Alternating votes:** pulses alternate between cnt=5 and cnt=45 -> acc toggles between 0 and ±1 and the period stays 50 forever.
- **Opposite-cancel:** drive pend_short, then 4 lead votes before the wrap -> both flags clear and the period stays 50.
- **Lock:** 8 edges at cnt=0 -> locked=1 the cycle after the 8th edge. Then remove pulses -> locked=0 after 200 cycles of silence. One edge at cnt=20 while locked -> locked=0 the next cycle.

Source files
------------

// File: rtl/dpll_phase_track.sv
// Digital phase-tracking loop: a divide-by-DIV counter is nudged one count
// shorter or longer per period, driven by lead/lag votes from incoming edge
// pulses that are filtered through a random-walk counter. Also reports lock.
module dpll_phase_track #(
    parameter int DIV    = 50,
    parameter int K      = 4,
    parameter int LOCK_N = 8
) (
    input  logic clk_50K,
    input  logic rst_n,
    input  logic pulse,
    output logic rclk,
    output logic sync_tick,
    output logic lead,
    output logic lag,
    output logic locked
);

    localparam int CW = $clog2(DIV + 1);
    localparam int SW = $clog2(4 * DIV + 1);
    localparam int RW = $clog2(LOCK_N + 1);

    localparam logic [CW-1:0] C_DIV  = CW'(DIV);
    localparam logic [CW-1:0] C_DM1  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_DM2  = CW'(DIV - 2);
    localparam logic [CW-1:0] C_HALF = CW'(DIV / 2);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [SW-1:0] S_MAX  = SW'(4 * DIV);
    localparam logic [SW-1:0] S_HIT  = SW'(4 * DIV - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);

    localparam logic [RW-1:0] R_MAX  = RW'(LOCK_N);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    localparam logic signed [4:0] ACC_POS = 5'(K);
    localparam logic signed [4:0] ACC_NEG = 5'(-K);
    localparam logic signed [4:0] ACC_ONE = 5'sd1;

    logic [CW-1:0]     cnt;
    logic signed [4:0] acc;
    logic              pend_short;
    logic              pend_long;
    logic [RW-1:0]     run;
    logic [SW-1:0]     silence;

    logic              apply_short;
    logic              apply_long;
    logic              wrap;
    logic              vote_lead;
    logic              vote_lag;
    logic [CW-1:0]     err;
    logic              good_edge;
    logic signed [4:0] acc_step;
    logic              req_short;
    logic              req_long;
    logic              short_base;
    logic              long_base;
    logic signed [4:0] acc_next;
    logic              short_next;
    logic              long_next;

    // Divider terminal decode. A pending shorten that is already past DIV-2
    // falls through to the normal DIV-1 wrap and stays pending a period.
    always_comb begin
        apply_short = pend_short && (cnt == C_DM2);
        apply_long  = pend_long && (cnt == C_DIV);
        wrap        = apply_short || (cnt >= C_DIV) || ((cnt == C_DM1) && !pend_long);
    end

    // Phase detector on the pre-wrap count: early half votes lead, late half lag.
    always_comb begin
        vote_lead = 1'b0;
        vote_lag  = 1'b0;
        err       = '0;
        if (pulse && (cnt != '0) && (cnt != C_DIV)) begin
            if (cnt <= C_HALF) begin
                vote_lead = 1'b1;
                err       = cnt;
            end else begin
                vote_lag = 1'b1;
                err      = C_DIV - cnt;
            end
        end
        good_edge = (err <= C_ONE);
    end

    // Random-walk filter: the wrap that applies a correction clears its flag
    // first, then a new request sets, holds or cancels against what remains.
    always_comb begin
        acc_step   = vote_lag ? (acc + ACC_ONE) : (acc - ACC_ONE);
        req_short  = vote_lag && (acc_step == ACC_POS);
        req_long   = vote_lead && (acc_step == ACC_NEG);
        short_base = pend_short && !apply_short;
        long_base  = pend_long && !apply_long;
        acc_next   = acc;
        short_next = short_base;
        long_next  = long_base;
        if (req_short) begin
            acc_next = '0;
            if (long_base) long_next = 1'b0;
            else           short_next = 1'b1;
        end else if (req_long) begin
            acc_next = '0;
            if (short_base) short_next = 1'b0;
            else            long_next = 1'b1;
        end else if (vote_lead || vote_lag) begin
            acc_next = acc_step;
        end
    end

    // Divider counter and registered strobes / recovered clock.
    always_ff @(posedge clk_50K) begin
        if (!rst_n) begin
            cnt       <= '0;
            rclk      <= 1'b0;
            sync_tick <= 1'b0;
            lead      <= 1'b0;
            lag       <= 1'b0;
        end else begin
            cnt       <= wrap ? '0 : (cnt + C_ONE);
            rclk      <= (cnt >= C_HALF);
            sync_tick <= wrap;
            lead      <= vote_lead;
            lag       <= vote_lag;
        end
    end

    // Filter accumulator and pending correction flags.
    always_ff @(posedge clk_50K) begin
        if (!rst_n) begin
            acc        <= '0;
            pend_short <= 1'b0;
            pend_long  <= 1'b0;
        end else begin
            acc        <= acc_next;
            pend_short <= short_next;
            pend_long  <= long_next;
        end
    end

    // Lock detector: run of good edges, cleared by a bad edge or long silence.
    always_ff @(posedge clk_50K) begin
        if (!rst_n) begin
            run     <= '0;
            silence <= '0;
        end else if (pulse) begin
            silence <= '0;
            if (good_edge) begin
                if (run != R_MAX) run <= run + R_ONE;
            end else begin
                run <= '0;
            end
        end else begin
            if (silence != S_MAX) silence <= silence + S_ONE;
            if (silence >= S_HIT) run <= '0;
        end
    end

    assign locked = (run == R_MAX);

endmodule

// File: tb/tb_dpll_phase_track.sv
// Self-checking bench for dpll_phase_track: directed phases from the test
// plan plus a randomized tail, all checked cycle by cycle against a model.
`timescale 1ns/1ps
module tb_dpll_phase_track;
  localparam int DIV    = 50;
  localparam int K      = 4;
  localparam int LOCK_N = 8;

  logic clk_50K = 1'b0;
  logic rst_n   = 1'b0;
  logic pulse   = 1'b0;
  logic rclk, sync_tick, lead, lag, locked;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  int m_cnt = 0, m_acc = 0, m_run = 0, m_sil = 0;
  bit m_ps = 0, m_pl = 0;
  logic [4:0] exp_q[$];

  // observation bookkeeping
  int tick_q[$];
  int lead_seen = 0, lag_seen = 0, rclk_hi = 0;
  int rst_cyc = 0, mark = 0;

  dpll_phase_track #(.DIV(DIV), .K(K), .LOCK_N(LOCK_N)) dut (
    .clk_50K(clk_50K), .rst_n(rst_n), .pulse(pulse), .rclk(rclk),
    .sync_tick(sync_tick), .lead(lead), .lag(lag), .locked(locked)
  );

  // clock
  always #10 clk_50K = ~clk_50K;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: one clock edge of the loop, from the pre-edge state.
  task automatic model_step(input logic p, input logic r);
    int term, err, vote;
    bit wrap, applied;
    logic e_rclk, e_tick, e_lead, e_lag, e_lock;
    if (!r) begin
      m_cnt = 0; m_acc = 0; m_ps = 0; m_pl = 0; m_run = 0; m_sil = 0;
      exp_q.push_back(5'b0);
      return;
    end
    e_rclk = (m_cnt >= DIV / 2);
    term = m_ps ? DIV - 2 : (m_pl ? DIV : DIV - 1);
    wrap = (m_cnt >= term);
    applied = (m_cnt == term) && (m_ps || m_pl);
    vote = 0;
    err = 0;
    if (p && m_cnt != 0 && m_cnt != DIV) begin
      if (m_cnt <= DIV / 2) begin vote = -1; err = m_cnt; end
      else begin vote = 1; err = DIV - m_cnt; end
    end
    e_tick = wrap;
    e_lead = (vote < 0);
    e_lag = (vote > 0);
    m_cnt = wrap ? 0 : m_cnt + 1;
    if (applied) begin m_ps = 0; m_pl = 0; end
    if (vote != 0) begin
      m_acc = m_acc + vote;
      if (m_acc == K) begin
        m_acc = 0;
        if (m_pl) m_pl = 0; else m_ps = 1;
      end else if (m_acc == -K) begin
        m_acc = 0;
        if (m_ps) m_ps = 0; else m_pl = 1;
      end
    end
    if (p) begin
      m_sil = 0;
      if (err <= 1) m_run = (m_run < LOCK_N) ? m_run + 1 : LOCK_N;
      else m_run = 0;
    end else begin
      m_sil = (m_sil < 4 * DIV) ? m_sil + 1 : 4 * DIV;
      if (m_sil == 4 * DIV) m_run = 0;
    end
    e_lock = (m_run == LOCK_N);
    exp_q.push_back({e_rclk, e_tick, e_lead, e_lag, e_lock});
  endtask

  // driver: one clock with the given pulse value, then check all outputs
  task automatic cycle(input logic p);
    logic [4:0] e;
    pulse = p;
    @(posedge clk_50K);
    model_step(p, rst_n);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("rclk", rclk, e[4]);
    check("sync_tick", sync_tick, e[3]);
    check("lead", lead, e[2]);
    check("lag", lag, e[1]);
    check("locked", locked, e[0]);
    if (sync_tick === 1'b1) tick_q.push_back(cyc);
    if (lead === 1'b1) lead_seen++;
    if (lag === 1'b1) lag_seen++;
    if (rclk === 1'b1) rclk_hi++;
  endtask

  // wait (bounded) until the model count equals tgt, then pulse on that cycle
  task automatic pulse_at(input int tgt);
    int n = 0;
    while (m_cnt != tgt && n < 200) begin
      cycle(1'b0);
      n++;
    end
    check("pulse_at_bound", n < 200, 1);
    cycle(1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b1);
    cycle(1'b0);
    rst_n = 1'b1;
    tick_q.delete();
    lead_seen = 0;
    lag_seen = 0;
  endtask

  function automatic int n_iv(input int v);
    int c = 0;
    for (int i = 1; i < tick_q.size(); i++)
      if (tick_q[i] - tick_q[i-1] == v) c++;
    return c;
  endfunction

  function automatic int n_iv_ne(input int v);
    int c = 0;
    for (int i = 1; i < tick_q.size(); i++)
      if (tick_q[i] - tick_q[i-1] != v) c++;
    return c;
  endfunction

  initial begin
    // reset held 3 cycles with pulse high
    rst_n = 1'b0;
    repeat (3) cycle(1'b1);
    check("reset_locked", locked, 0);
    check("reset_tick", sync_tick, 0);
    rst_n = 1'b1;
    rst_cyc = cyc;
    tick_q.delete();
    rclk_hi = 0;
    repeat (50) cycle(1'b0);
    check("rclk_duty", rclk_hi, 25);
    repeat (60) cycle(1'b0);
    check("tick_count", tick_q.size(), 2);
    check("first_tick", (tick_q.size() > 0) ? tick_q[0] - rst_cyc : -1, 50);
    check("tick_period", (tick_q.size() > 1) ? tick_q[1] - tick_q[0] : -1, 50);

    // lead pull-in: input edges every 50 cycles, first at cnt=10
    do_reset();
    pulse_at(10);
    for (int i = 2; i <= 48; i++) begin
      repeat (49) cycle(1'b0);
      cycle(1'b1);
      if (i == 40) mark = lead_seen;
    end
    check("lead_votes", lead_seen, 40);
    check("lead_stopped", lead_seen - mark, 0);
    check("lead_long_periods", n_iv(51), 10);
    check("lead_no_lag", lag_seen, 0);
    check("lead_locked", locked, 1);

    // lag pull-in: input edges every 50 cycles, first at cnt=40
    do_reset();
    pulse_at(40);
    for (int i = 2; i <= 48; i++) begin
      repeat (49) cycle(1'b0);
      cycle(1'b1);
      if (i == 40) mark = lag_seen;
    end
    check("lag_votes", lag_seen, 40);
    check("lag_stopped", lag_seen - mark, 0);
    check("lag_short_periods", n_iv(49), 10);
    check("lag_locked", locked, 1);

    // alternating lead/lag votes never trigger a correction
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pulse_at(5);
      pulse_at(45);
    end
    repeat (60) cycle(1'b0);
    check("alt_lead", lead_seen, 10);
    check("alt_lag", lag_seen, 10);
    check("alt_periods_gt0", tick_q.size() > 5, 1);
    check("alt_period_50", n_iv_ne(50), 0);

    // opposite-cancel: pend_short set at cnt=49, then 4 back-to-back leads
    do_reset();
    repeat (4) pulse_at(49);
    pulse_at(1);
    repeat (3) cycle(1'b1);
    repeat (150) cycle(1'b0);
    check("cancel_lag", lag_seen, 4);
    check("cancel_lead", lead_seen, 4);
    check("cancel_period_50", n_iv_ne(50), 0);

    // lock, loss of lock by silence, loss of lock by a bad edge
    do_reset();
    repeat (7) pulse_at(0);
    check("lock_7", locked, 0);
    pulse_at(0);
    check("lock_8", locked, 1);
    repeat (199) cycle(1'b0);
    check("silence_199", locked, 1);
    cycle(1'b0);
    check("silence_200", locked, 0);
    repeat (8) pulse_at(0);
    check("relock", locked, 1);
    pulse_at(20);
    check("bad_edge_unlock", locked, 0);

    // randomized tail, including resets mid-correction
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        rst_n = 1'b0;
        cycle(1'($urandom_range(0, 1)));
        rst_n = 1'b1;
      end else if (r < 4) begin
        pulse_at(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(DIV - 3, DIV - 1));
      end else if (r < 6) begin
        pulse_at($urandom_range(0, DIV - 1));
      end else begin
        repeat ($urandom_range(1, 30)) cycle(1'($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
